// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults and receiver states.
// Used by both the receiver and the transmitter side.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK_WAIT
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs.
// RESET_VAL sets the value both flops take in reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver on a 16x oversample strobe.
// Emits bytes on valid/ready; flags framing errors and overruns.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxclk_en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic rx_s;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  rx_state_t            state, state_n;
  logic [TW-1:0]        tick, tick_n;
  logic [BW-1:0]        bitn, bitn_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [DATA_BITS-1:0] data_n;
  logic                 valid_n;
  logic                 ferr_n;
  logic                 ovr_n;
  logic                 deliver;

  always_comb begin
    state_n = state;
    tick_n  = tick;
    bitn_n  = bitn;
    shreg_n = shreg;
    data_n  = data;
    valid_n = valid;
    ferr_n  = 1'b0;
    ovr_n   = 1'b0;
    deliver = 1'b0;

    if (valid && ready) valid_n = 1'b0;

    if (rxclk_en) begin
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state_n = START;
            tick_n  = '0;
          end
        end
        START: begin
          if (tick == T_MID) begin
            tick_n  = '0;
            bitn_n  = '0;
            state_n = rx_s ? IDLE : DATA;
          end else begin
            tick_n = tick + 1'b1;
          end
        end
        DATA: begin
          if (tick == T_END) begin
            tick_n  = '0;
            shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
            bitn_n  = bitn + 1'b1;
            if (bitn == B_LAST) state_n = STOP;
          end else begin
            tick_n = tick + 1'b1;
          end
        end
        STOP: begin
          if (tick == T_END) begin
            tick_n = '0;
            if (rx_s) begin
              deliver = 1'b1;
              state_n = IDLE;
            end else begin
              ferr_n  = 1'b1;
              state_n = BREAK_WAIT;
            end
          end else begin
            tick_n = tick + 1'b1;
          end
        end
        BREAK_WAIT: begin
          // hold off restarts until the line idles high again
          if (rx_s) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end

    if (deliver) begin
      if (!valid || ready) begin
        data_n  = shreg;
        valid_n = 1'b1;
      end else begin
        ovr_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tick      <= '0;
      bitn      <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      tick      <= tick_n;
      bitn      <= bitn_n;
      shreg     <= shreg_n;
      data      <= data_n;
      valid     <= valid_n;
      frame_err <= ferr_n;
      overrun   <= ovr_n;
    end
  end

endmodule
